// File: rtl/vga_port_hub.sv
// ----------------------------------------------------------------------------
// vga_port_hub
//
// Collects pixel write requests from NCH host ports and streams them, in the
// order they were granted, to a framebuffer write port through a small FIFO.
// Each host port runs a 4-phase handshake (HE request / service acknowledge).
// A round-robin arbiter grants at most one port per cycle. Read requests are
// not supported: they are acknowledged normally, push nothing, and set a
// sticky per-port error flag.
//
// Ports
//   CLOCK_50    in   sole clock, rising edge
//   RESET_N     in   synchronous active-low reset
//   HE          in   [NCH]        per-port request
//   HRW         in   [NCH]        per-port direction, 1 = write, 0 = read
//   host_addr   in   [NCH*ADDR_W] per-port pixel address, port i at [i*ADDR_W +: ADDR_W]
//   host_dat    in   [NCH*DATA_W] per-port pixel data, port i at [i*DATA_W +: DATA_W]
//   service     out  [NCH]        per-port acknowledge (high while in ACK)
//   fb_we       out               framebuffer write valid (FIFO not empty)
//   fb_addr     out  [ADDR_W]     FIFO head address
//   fb_data     out  [DATA_W]     FIFO head data
//   fb_ready    in                framebuffer accepts the head entry
//   fifo_level  out  [clog2(DEPTH)+1] FIFO occupancy
//   rd_err      out  [NCH]        sticky: a read request was granted
// ----------------------------------------------------------------------------
module vga_port_hub #(
    parameter int NCH    = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic [NCH-1:0]            HE,
    input  logic [NCH-1:0]            HRW,
    input  logic [NCH*ADDR_W-1:0]     host_addr,
    input  logic [NCH*DATA_W-1:0]     host_dat,
    output logic [NCH-1:0]            service,
    output logic                      fb_we,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic [DATA_W-1:0]         fb_data,
    input  logic                      fb_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [NCH-1:0]            rd_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ch_state_t;

    ch_state_t              state_r      [NCH];
    ch_state_t              state_next_s [NCH];

    logic [NCH-1:0]         req_s;
    logic [NCH-1:0]         grant_s;
    logic [CH_W-1:0]        grant_idx_s;
    logic [CH_W-1:0]        last_r;
    logic [ENT_W-1:0]       push_entry_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   full_s;

    logic [ENT_W-1:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [NCH-1:0]         rd_err_r;

    // Fullness comes from the registered count only; a pop in the same cycle
    // does not free a slot for a push until the following edge.
    assign full_s = (count_r == CNT_W'(DEPTH));
    assign pop_s  = (count_r != {CNT_W{1'b0}}) && fb_ready;
    assign push_s = |(grant_s & HRW);

    // Requesters: idle ports with HE high; writes are held off while full.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if ((state_r[i] == ST_IDLE) && HE[i] && (!HRW[i] || !full_s)) begin
                req_s[i] = 1'b1;
            end else begin
                req_s[i] = 1'b0;
            end
        end
    end

    // Round-robin arbiter: first requester found starting after last grant.
    always_comb begin : arb
        int  idx;
        logic found;
        grant_s      = '0;
        grant_idx_s  = last_r;
        push_entry_s = '0;
        found        = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(last_r) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end else begin
                idx = idx;
            end
            if (!found && req_s[idx]) begin
                found        = 1'b1;
                grant_s[idx] = 1'b1;
                grant_idx_s  = CH_W'(idx);
                push_entry_s = {host_addr[idx*ADDR_W +: ADDR_W],
                                host_dat[idx*DATA_W +: DATA_W]};
            end else begin
                grant_s[idx] = grant_s[idx];
            end
        end
    end

    // Per-port handshake next state: IDLE -> ACK on grant, ACK -> IDLE on HE low.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_next_s[i] = state_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (grant_s[i]) begin
                        state_next_s[i] = ST_ACK;
                    end else begin
                        state_next_s[i] = ST_IDLE;
                    end
                end
                ST_ACK: begin
                    if (!HE[i]) begin
                        state_next_s[i] = ST_IDLE;
                    end else begin
                        state_next_s[i] = ST_ACK;
                    end
                end
                default: state_next_s[i] = ST_IDLE;
            endcase
        end
    end

    // Port state registers.
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < NCH; i++) begin
            if (!RESET_N) begin
                state_r[i] <= ST_IDLE;
            end else begin
                state_r[i] <= state_next_s[i];
            end
        end
    end

    // Arbiter history, sticky read-error flags, FIFO pointers and count.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            last_r   <= CH_W'(NCH - 1);
            rd_err_r <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (|grant_s) begin
                last_r <= grant_idx_s;
            end
            rd_err_r <= rd_err_r | (grant_s & ~HRW);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care whenever count is zero.
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            service[i] = (state_r[i] == ST_ACK);
        end
    end

    assign fb_we      = (count_r != {CNT_W{1'b0}});
    assign fb_addr    = mem_r[rd_ptr_r][ENT_W-1:DATA_W];
    assign fb_data    = mem_r[rd_ptr_r][DATA_W-1:0];
    assign fifo_level = count_r;
    assign rd_err     = rd_err_r;

endmodule

// File: tb/tb_vga_port_hub.sv
// ----------------------------------------------------------------------------
// tb_vga_port_hub
//
// Directed bench for vga_port_hub with NCH=2, DATA_W=16, ADDR_W=16, DEPTH=8.
// A vector table covers the single write, alternating round-robin grants and
// a read request; hand-written sequences cover FIFO full / pop-then-push and
// reset with queued entries and an open handshake.
// ----------------------------------------------------------------------------
module tb_vga_port_hub;

    logic        CLOCK_50;
    logic        RESET_N;
    logic [1:0]  HE;
    logic [1:0]  HRW;
    logic [31:0] host_addr;
    logic [31:0] host_dat;
    logic [1:0]  service;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_ready;
    logic [3:0]  fifo_level;
    logic [1:0]  rd_err;

    int tests;
    int fails;

    vga_port_hub #(
        .NCH(2), .DATA_W(16), .ADDR_W(16), .DEPTH(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .HE(HE), .HRW(HRW),
        .host_addr(host_addr), .host_dat(host_dat), .service(service),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ready(fb_ready), .fifo_level(fifo_level), .rd_err(rd_err)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [1:0]  he;
        logic [1:0]  hrw;
        logic [15:0] a0, d0, a1, d1;
        logic        rdy;
        logic [1:0]  svc;
        logic        we;
        logic [15:0] fa, fd;
        logic [3:0]  lvl;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] he, input logic [1:0] hrw,
                         input logic [15:0] a0, input logic [15:0] d0,
                         input logic [15:0] a1, input logic [15:0] d1,
                         input logic rdy);
        HE        = he;
        HRW       = hrw;
        host_addr = {a1, a0};
        host_dat  = {d1, d0};
        fb_ready  = rdy;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //            he     hrw    a0       d0       a1       d1       rdy   svc    we    fa       fd       lvl   err
        vecs[0]  = '{2'b01, 2'b01, 16'h0010, 16'hF800, 16'h0000, 16'h0000, 1'b1, 2'b01, 1'b1, 16'h0010, 16'hF800, 4'd1, 2'b00};
        vecs[1]  = '{2'b00, 2'b01, 16'h0010, 16'hF800, 16'h0000, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'd0, 2'b00};
        vecs[2]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'd0, 2'b00};
        vecs[3]  = '{2'b11, 2'b11, 16'h0100, 16'h1111, 16'h0200, 16'h2222, 1'b0, 2'b10, 1'b1, 16'h0200, 16'h2222, 4'd1, 2'b00};
        vecs[4]  = '{2'b01, 2'b11, 16'h0100, 16'h1111, 16'h0200, 16'h2222, 1'b0, 2'b01, 1'b1, 16'h0200, 16'h2222, 4'd2, 2'b00};
        vecs[5]  = '{2'b10, 2'b11, 16'h0100, 16'h1111, 16'h0201, 16'h2223, 1'b0, 2'b10, 1'b1, 16'h0200, 16'h2222, 4'd3, 2'b00};
        vecs[6]  = '{2'b01, 2'b11, 16'h0101, 16'h1112, 16'h0201, 16'h2223, 1'b0, 2'b01, 1'b1, 16'h0200, 16'h2222, 4'd4, 2'b00};
        vecs[7]  = '{2'b00, 2'b11, 16'h0101, 16'h1112, 16'h0201, 16'h2223, 1'b1, 2'b00, 1'b1, 16'h0100, 16'h1111, 4'd3, 2'b00};
        vecs[8]  = '{2'b00, 2'b11, 16'h0101, 16'h1112, 16'h0201, 16'h2223, 1'b1, 2'b00, 1'b1, 16'h0201, 16'h2223, 4'd2, 2'b00};
        vecs[9]  = '{2'b00, 2'b11, 16'h0101, 16'h1112, 16'h0201, 16'h2223, 1'b1, 2'b00, 1'b1, 16'h0101, 16'h1112, 4'd1, 2'b00};
        vecs[10] = '{2'b00, 2'b11, 16'h0101, 16'h1112, 16'h0201, 16'h2223, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'd0, 2'b00};
        vecs[11] = '{2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0300, 16'h3333, 1'b1, 2'b10, 1'b0, 16'h0000, 16'h0000, 4'd0, 2'b10};
        vecs[12] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0300, 16'h3333, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'd0, 2'b10};

        // Reset
        RESET_N = 1'b0;
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        chk("reset service", 32'(service), 32'h0);
        chk("reset fb_we", 32'(fb_we), 32'h0);
        chk("reset level", 32'(fifo_level), 32'h0);
        chk("reset rd_err", 32'(rd_err), 32'h0);
        RESET_N = 1'b1;

        // Table: single write, alternating grants, read request
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].he, vecs[v].hrw, vecs[v].a0, vecs[v].d0,
                  vecs[v].a1, vecs[v].d1, vecs[v].rdy);
            tick();
            chk($sformatf("v%0d service", v), 32'(service), 32'(vecs[v].svc));
            chk($sformatf("v%0d fb_we", v), 32'(fb_we), 32'(vecs[v].we));
            if (vecs[v].we) begin
                chk($sformatf("v%0d fb_addr", v), 32'(fb_addr), 32'(vecs[v].fa));
                chk($sformatf("v%0d fb_data", v), 32'(fb_data), 32'(vecs[v].fd));
            end
            chk($sformatf("v%0d level", v), 32'(fifo_level), 32'(vecs[v].lvl));
            chk($sformatf("v%0d rd_err", v), 32'(rd_err), 32'(vecs[v].err));
        end

        // Fill FIFO with 8 writes from ch0 while framebuffer stalls
        for (int n = 0; n < 8; n++) begin
            drive(2'b01, 2'b01, 16'h1000 + 16'(n), 16'hA000 + 16'(n), 16'h0, 16'h0, 1'b0);
            tick();
            chk($sformatf("fill%0d service", n), 32'(service), 32'h1);
            chk($sformatf("fill%0d level", n), 32'(fifo_level), 32'(n + 1));
            drive(2'b00, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
            tick();
            chk($sformatf("fill%0d release", n), 32'(service), 32'h0);
        end

        // Ninth write held while full
        drive(2'b01, 2'b01, 16'h1008, 16'hA008, 16'h0, 16'h0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("full hold%0d service", n), 32'(service), 32'h0);
            chk($sformatf("full hold%0d level", n), 32'(fifo_level), 32'h8);
        end
        chk("full head addr", 32'(fb_addr), 32'h1000);

        // Pop while full: no same-cycle push
        fb_ready = 1'b1;
        tick();
        chk("pop-full service", 32'(service), 32'h0);
        chk("pop-full level", 32'(fifo_level), 32'h7);

        // Push on the following edge
        fb_ready = 1'b0;
        tick();
        chk("late grant service", 32'(service), 32'h1);
        chk("late grant level", 32'(fifo_level), 32'h8);

        // Drain in order
        drive(2'b00, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d fb_we", k), 32'(fb_we), 32'h1);
            chk($sformatf("drain%0d fb_addr", k), 32'(fb_addr), 32'(16'h1001 + 16'(k)));
            chk($sformatf("drain%0d fb_data", k), 32'(fb_data), 32'(16'hA001 + 16'(k)));
            tick();
        end
        chk("drained level", 32'(fifo_level), 32'h0);
        chk("drained fb_we", 32'(fb_we), 32'h0);

        // Queue 3 entries, leave ch0 in ACK, then reset for one edge
        for (int n = 0; n < 3; n++) begin
            drive(2'b01, 2'b01, 16'h2000 + 16'(n), 16'hB000 + 16'(n), 16'h0, 16'h0, 1'b0);
            tick();
            if (n < 2) begin
                drive(2'b00, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
                tick();
            end
        end
        chk("pre-reset level", 32'(fifo_level), 32'h3);
        chk("pre-reset service", 32'(service), 32'h1);
        RESET_N = 1'b0;
        tick();
        chk("mid reset fb_we", 32'(fb_we), 32'h0);
        chk("mid reset service", 32'(service), 32'h0);
        chk("mid reset level", 32'(fifo_level), 32'h0);
        chk("mid reset rd_err", 32'(rd_err), 32'h0);
        RESET_N = 1'b1;
        drive(2'b00, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        tick();
        chk("post reset fb_we", 32'(fb_we), 32'h0);

        // After reset channel 0 has priority
        drive(2'b11, 2'b11, 16'h3000, 16'hC000, 16'h3100, 16'hC100, 1'b0);
        tick();
        chk("post reset grant", 32'(service), 32'h1);
        chk("post reset head", 32'(fb_addr), 32'h3000);
        drive(2'b10, 2'b11, 16'h3000, 16'hC000, 16'h3100, 16'hC100, 1'b0);
        tick();
        chk("post reset second grant", 32'(service), 32'h2);
        chk("post reset level", 32'(fifo_level), 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_port_hub.md
VGA_PORT_HUB -- requirements
Module: vga_port_hub

Interface
REQ-001 SHALL have parameter NCH, default 2, number of host port channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, pixel data width.
REQ-003 SHALL have parameter ADDR_W, default 16, framebuffer address width.
REQ-004 SHALL have parameter DEPTH, default 8, write FIFO depth (power of two, >=2).
REQ-005 SHALL have port CLOCK_50  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port RESET_N  input  1  synchronous, active-low reset.
REQ-007 SHALL have port HE  input  NCH  per-channel host enable (request).
REQ-008 SHALL have port HRW  input  NCH  per-channel direction: 1 = write, 0 = read (unsupported).
REQ-009 SHALL have port host_addr  input  NCH*ADDR_W  per-channel pixel address; channel i at [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port host_dat  input  NCH*DATA_W  per-channel pixel data; channel i at [i*DATA_W +: DATA_W].
REQ-011 SHALL have port service  output  NCH  per-channel acknowledge.
REQ-012 SHALL have port fb_we  output  1  framebuffer write valid.
REQ-013 SHALL have port fb_addr  output  ADDR_W  framebuffer write address.
REQ-014 SHALL have port fb_data  output  DATA_W  framebuffer write data.
REQ-015 SHALL have port fb_ready  input  1  framebuffer accepts the current write.
REQ-016 SHALL have port fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 SHALL have port rd_err  output  NCH  sticky per-channel flag: read request received.

Function
REQ-018 Each channel SHALL run a 4-phase FSM: IDLE -> ACK -> IDLE; service[i] = 1 exactly in ACK.
REQ-019 In IDLE with HE[i]=1, the channel SHALL be a requester; it leaves IDLE only when granted.
REQ-020 Arbiter SHALL grant at most one requester per cycle, round-robin: search starts at (last granted + 1) mod NCH; after reset, last granted = NCH-1 (channel 0 highest priority).
REQ-021 A write requester (HRW=1) SHALL be grantable only when the FIFO is not full, with fullness taken from the registered count and no credit for a same-cycle pop.
REQ-022 A read requester (HRW=0) SHALL be grantable regardless of FIFO state; its grant pushes nothing and sets rd_err[i]=1 at the grant edge.
REQ-023 At the grant edge, a write SHALL push {host_addr_i, host_dat_i}, and the channel SHALL enter ACK; service[i] goes high the following cycle (1-cycle latency from HE sampled).
REQ-024 In ACK, the channel SHALL return to IDLE on the first edge sampling HE[i]=0; service[i] drops the next cycle. A channel SHALL NOT be re-requested before HE[i] has been seen low.
REQ-025 fb_we SHALL equal (count != 0); fb_addr/fb_data SHALL present the FIFO head; a pop occurs on an edge with fb_we=1 and fb_ready=1.
REQ-026 A pushed entry SHALL appear on fb_we/fb_addr/fb_data in the same cycle service rises when the FIFO was empty.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO across channels.
REQ-028 fb_ready while empty SHALL have no effect; no push SHALL occur while full; entries SHALL never be dropped or duplicated.
REQ-029 fifo_level SHALL equal the registered count, 0..DEPTH.

Reset
REQ-030 With RESET_N=0 at an edge: all FSMs IDLE, service=0, count=0, pointers=0, fb_we=0, rd_err=0, and round-robin pointer = NCH-1, taking effect the cycle after.
REQ-031 Reset mid-handshake or with a non-empty FIFO SHALL discard all pending entries and acknowledgements; no write is emitted after reset until a new grant.

Verification
REQ-032 NCH=2: ch0 write addr 0x0010 data 0xF800, fb_ready=1 -> service[0] high 1 cycle after HE, fb_we=1 with 0x0010/0xF800 same cycle, popped next edge, fifo_level back to 0.
REQ-033 Both channels request continuously (HE held, released after service) -> grants alternate 0,1,0,1; FIFO output order matches grant order.
REQ-034 fb_ready=0, DEPTH=8, 9 writes -> fifo_level=8, 9th requester held with service=0 until one pop, then granted; all 9 drained in order.
REQ-035 Full FIFO with fb_ready=1 and pending write -> pop that cycle, push granted only on the following edge.
REQ-036 ch1 HRW=0 request -> service[1] handshake completes, rd_err=2'b10, fifo_level unchanged.
REQ-037 RESET_N low for one edge while 3 entries queued and ch0 in ACK -> fb_we=0, service=0, fifo_level=0, rd_err=0 next cycle.
